// File: rtl/pin_entry_collector_pkg.sv
// Shared definitions for the keypad PIN front-end and the gate controller
// that consumes its code word. Code width is derived from one place.
package pin_entry_collector_pkg;

  // Default PIN geometry; the gate controller sizes its code input from these.
  localparam int unsigned DEF_NUM_DIGITS = 4;
  localparam int unsigned DEF_DIGIT_W    = 4;
  localparam int unsigned DEF_CODE_W     = DEF_NUM_DIGITS * DEF_DIGIT_W;

  // PIN entry front-end state encoding.
  typedef enum logic [1:0] {
    PIN_IDLE    = 2'd0,
    PIN_COLLECT = 2'd1,
    PIN_ACK     = 2'd2,
    PIN_RELEASE = 2'd3
  } pin_state_e;

  // Width of a counter that must hold values 0..max_val (never less than 1 bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val < 32'd1) begin
      return 32'd1;
    end else begin
      return $clog2(max_val + 32'd1);
    end
  endfunction

endpackage

// File: rtl/pin_idle_timer.sv
// Clearable/loadable saturating up-counter with a terminal-count flag.
// Priority: clear > load > increment. The count never passes TC_VALUE.
module pin_idle_timer
  import pin_entry_collector_pkg::*;
#(
  parameter  int unsigned TC_VALUE = 1,
  localparam int unsigned W        = cnt_width(TC_VALUE)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_inc,
  output logic         o_tc
);

  localparam logic [W-1:0] TC = W'(TC_VALUE);

  logic [W-1:0] r_count;
  logic [W-1:0] w_load_sat;

  // Loaded values above the terminal count are clamped so the counter cannot exceed it.
  assign w_load_sat = (i_load_val > TC) ? TC : i_load_val;
  assign o_tc       = (r_count == TC);

  // Counter register: clear wins, then load, then saturating increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= w_load_sat;
    end else if (i_inc && !o_tc) begin
      r_count <= r_count + W'(1);
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/pin_entry_collector.sv
// Keypad front-end: assembles strobed digits into a PIN word, presents it
// with a held code_ack on enter, and handles clear, short/overlong entries
// and inactivity timeout so the gate controller only sees complete PINs.
module pin_entry_collector
  import pin_entry_collector_pkg::*;
#(
  parameter  int unsigned NUM_DIGITS     = DEF_NUM_DIGITS,
  parameter  int unsigned DIGIT_W        = DEF_DIGIT_W,
  parameter  int unsigned ACK_CYCLES     = 2,
  parameter  int unsigned TIMEOUT_CYCLES = 1000,
  localparam int unsigned CODE_W         = NUM_DIGITS * DIGIT_W,
  localparam int unsigned CNT_W          = $clog2(NUM_DIGITS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_value,
  input  logic               key_enter,
  input  logic               key_clear,
  output logic [CODE_W-1:0]  code,
  output logic               code_ack,
  output logic [CNT_W-1:0]   digit_count,
  output logic               entry_error,
  output logic               timeout
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_DIGITS);

  pin_state_e        r_state;
  pin_state_e        w_state_nxt;
  logic [CODE_W-1:0] r_code;
  logic [CODE_W-1:0] w_code_nxt;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              r_ack;
  logic              w_ack_nxt;
  logic              r_err;
  logic              w_err_nxt;
  logic              r_to;
  logic              w_to_nxt;

  logic              w_any_key;
  logic              w_full;
  logic              w_in_collect;
  logic              w_idle_inc;
  logic              w_idle_clr;
  logic              w_idle_tc;
  logic              w_timeout_fire;
  logic              w_ack_inc;
  logic              w_ack_tc;
  logic [CODE_W-1:0] w_shifted;

  assign w_any_key    = key_valid | key_enter | key_clear;
  assign w_full       = (r_count == FULL);
  assign w_in_collect = arm && (r_state == PIN_COLLECT);

  // Idle timer runs only while a partial entry is held and no key arrives.
  // Its terminal count is one below the firing point so the timeout takes
  // effect on the very edge at which the idle count would reach TIMEOUT_CYCLES-1.
  assign w_idle_inc     = w_in_collect && !w_any_key && (r_count != '0);
  assign w_timeout_fire = w_idle_inc && w_idle_tc;
  assign w_idle_clr     = !w_in_collect || w_any_key || w_timeout_fire;

  // ACK hold timer counts cycles spent in ACK; it is held at zero elsewhere.
  assign w_ack_inc = arm && (r_state == PIN_ACK);

  // New digit enters the least significant nibble; first digit ends up in the MS nibble.
  assign w_shifted = (r_code << DIGIT_W) | CODE_W'(key_value);

  pin_idle_timer #(
    .TC_VALUE (TIMEOUT_CYCLES - 2)
  ) u_idle_timer (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_idle_clr),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_inc      (w_idle_inc),
    .o_tc       (w_idle_tc)
  );

  pin_idle_timer #(
    .TC_VALUE (ACK_CYCLES - 1)
  ) u_ack_timer (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (!w_ack_inc),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_inc      (w_ack_inc),
    .o_tc       (w_ack_tc)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= PIN_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; dropping arm always returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    if (!arm) begin
      w_state_nxt = PIN_IDLE;
    end else begin
      case (r_state)
        PIN_IDLE:    w_state_nxt = PIN_COLLECT;
        PIN_COLLECT: begin
          if (!key_clear && key_enter && w_full) begin
            w_state_nxt = PIN_ACK;
          end else begin
            w_state_nxt = PIN_COLLECT;
          end
        end
        PIN_ACK: begin
          if (w_ack_tc) begin
            w_state_nxt = PIN_RELEASE;
          end else begin
            w_state_nxt = PIN_ACK;
          end
        end
        PIN_RELEASE: w_state_nxt = PIN_COLLECT;
        default:     w_state_nxt = PIN_IDLE;
      endcase
    end
  end

  // Output/datapath next values; COLLECT priority is clear > enter > digit > timeout.
  always_comb begin
    w_code_nxt  = r_code;
    w_count_nxt = r_count;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_to_nxt    = 1'b0;
    if (!arm) begin
      w_code_nxt  = '0;
      w_count_nxt = '0;
    end else begin
      case (r_state)
        PIN_IDLE: begin
          w_code_nxt  = '0;
          w_count_nxt = '0;
        end
        PIN_COLLECT: begin
          if (key_clear) begin
            w_code_nxt  = '0;
            w_count_nxt = '0;
          end else if (key_enter) begin
            if (w_full) begin
              w_ack_nxt = 1'b1;
            end else begin
              w_err_nxt   = 1'b1;
              w_code_nxt  = '0;
              w_count_nxt = '0;
            end
          end else if (key_valid) begin
            if (w_full) begin
              w_err_nxt = 1'b1;
            end else begin
              w_code_nxt  = w_shifted;
              w_count_nxt = r_count + CNT_W'(1);
            end
          end else if (w_timeout_fire) begin
            w_to_nxt    = 1'b1;
            w_code_nxt  = '0;
            w_count_nxt = '0;
          end else begin
            w_code_nxt = r_code;
          end
        end
        PIN_ACK: begin
          if (w_ack_tc) begin
            w_code_nxt  = '0;
            w_count_nxt = '0;
          end else begin
            w_ack_nxt = 1'b1;
          end
        end
        PIN_RELEASE: begin
          w_code_nxt  = '0;
          w_count_nxt = '0;
        end
        default: begin
          w_code_nxt  = '0;
          w_count_nxt = '0;
        end
      endcase
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_code  <= '0;
      r_count <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_code  <= w_code_nxt;
      r_count <= w_count_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_to    <= w_to_nxt;
    end
  end

  assign code        = r_code;
  assign code_ack    = r_ack;
  assign digit_count = r_count;
  assign entry_error = r_err;
  assign timeout     = r_to;

endmodule

// File: tb/tb_pin_entry_collector.sv
// Directed bench for pin_entry_collector with an expected-PIN scoreboard.
module tb_pin_entry_collector;

  localparam int unsigned ND = 4;
  localparam int unsigned DW = 4;
  localparam int unsigned AC = 2;
  localparam int unsigned TO = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm;
  logic        key_valid;
  logic [3:0]  key_value;
  logic        key_enter;
  logic        key_clear;
  logic [15:0] code;
  logic        code_ack;
  logic [2:0]  digit_count;
  logic        entry_error;
  logic        timeout;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_q[$];
  logic [15:0] m_code;

  pin_entry_collector #(
    .NUM_DIGITS     (ND),
    .DIGIT_W        (DW),
    .ACK_CYCLES     (AC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .arm         (arm),
    .key_valid   (key_valid),
    .key_value   (key_value),
    .key_enter   (key_enter),
    .key_clear   (key_clear),
    .code        (code),
    .code_ack    (code_ack),
    .digit_count (digit_count),
    .entry_error (entry_error),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1;
    key_value = d;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic enter();
    key_enter = 1'b1;
    tick();
    key_enter = 1'b0;
  endtask

  // Key in all digits of pin, updating the bench model and checking the count.
  task automatic key_pin(input string tag, input logic [15:0] pin);
    logic [3:0] d;
    m_code = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      d = pin[15 - 4*i -: 4];
      press(d);
      m_code = {m_code[11:0], d};
      chk({tag, "_count"}, 32'(digit_count), 32'(i + 1));
    end
    chk({tag, "_code"}, 32'(code), 32'(m_code));
  endtask

  // Called at the cycle after enter: consume the ACK window and the release cycle.
  task automatic drain_ack(input string tag);
    int          hi;
    logic [15:0] e;
    hi = 0;
    e  = 16'h0000;
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end else begin
      e = 16'h0000;
    end
    for (int i = 0; i < int'(AC) + 4 && code_ack === 1'b1; i++) begin
      chk({tag, "_ackcode"}, 32'(code), 32'(e));
      hi++;
      tick();
    end
    chk({tag, "_acklen"}, 32'(hi), 32'(AC));
    chk({tag, "_rel_ack"}, 32'(code_ack), 32'd0);
    chk({tag, "_rel_code"}, 32'(code), 32'd0);
    chk({tag, "_rel_count"}, 32'(digit_count), 32'd0);
    tick();
  endtask

  initial begin
    int          first;
    int          pulses;
    logic [15:0] code_at;

    rst       = 1'b1;
    arm       = 1'b0;
    key_valid = 1'b0;
    key_value = 4'h0;
    key_enter = 1'b0;
    key_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_code", 32'(code), 32'd0);
    chk("rst_ack", 32'(code_ack), 32'd0);
    chk("rst_count", 32'(digit_count), 32'd0);
    chk("rst_err", 32'(entry_error), 32'd0);
    chk("rst_to", 32'(timeout), 32'd0);
    rst = 1'b0;
    tick();

    // Keys ignored while unarmed.
    press(4'h5);
    chk("idle_ignore", 32'(digit_count), 32'd0);

    // Full PIN 5990.
    arm = 1'b1;
    tick();
    key_pin("pin5990", 16'h5990);
    exp_q.push_back(m_code);
    enter();
    drain_ack("pin5990");

    // Short entry.
    press(4'h1);
    press(4'h2);
    enter();
    chk("short_err", 32'(entry_error), 32'd1);
    chk("short_ack", 32'(code_ack), 32'd0);
    chk("short_code", 32'(code), 32'd0);
    chk("short_count", 32'(digit_count), 32'd0);
    tick();
    chk("short_err_end", 32'(entry_error), 32'd0);
    chk("short_ack_end", 32'(code_ack), 32'd0);

    // Overflow digit is dropped, then the held PIN is submitted.
    key_pin("pin1234", 16'h1234);
    press(4'h7);
    chk("ovf_err", 32'(entry_error), 32'd1);
    chk("ovf_code", 32'(code), 32'(m_code));
    chk("ovf_count", 32'(digit_count), 32'd4);
    exp_q.push_back(m_code);
    enter();
    chk("ovf_err_end", 32'(entry_error), 32'd0);
    drain_ack("pin1234");

    // Inactivity timeout after a single digit.
    press(4'h8);
    chk("to_count", 32'(digit_count), 32'd1);
    first   = -1;
    pulses  = 0;
    code_at = 16'hffff;
    for (int i = 1; i <= int'(TO) + 10; i++) begin
      tick();
      if (timeout === 1'b1) begin
        pulses++;
        if (first < 0) begin
          first   = i;
          code_at = code;
        end
      end
    end
    chk("to_latency", 32'(first), 32'(TO - 1));
    chk("to_pulses", 32'(pulses), 32'd1);
    chk("to_code", 32'(code_at), 32'd0);
    chk("to_count_end", 32'(digit_count), 32'd0);
    pulses = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (timeout === 1'b1) pulses++;
    end
    chk("to_no_repeat", 32'(pulses), 32'd0);

    // Clear beats enter and digit in the same cycle.
    key_pin("coll", 16'h4321);
    key_valid = 1'b1;
    key_value = 4'h5;
    key_enter = 1'b1;
    key_clear = 1'b1;
    tick();
    key_valid = 1'b0;
    key_enter = 1'b0;
    key_clear = 1'b0;
    chk("coll_code", 32'(code), 32'd0);
    chk("coll_count", 32'(digit_count), 32'd0);
    chk("coll_err", 32'(entry_error), 32'd0);
    chk("coll_ack", 32'(code_ack), 32'd0);
    tick();
    chk("coll_ack2", 32'(code_ack), 32'd0);

    // Arm drop during entry.
    press(4'h3);
    press(4'h6);
    chk("arm_count", 32'(digit_count), 32'd2);
    chk("arm_code", 32'(code), 32'h36);
    arm = 1'b0;
    tick();
    chk("disarm_count", 32'(digit_count), 32'd0);
    chk("disarm_code", 32'(code), 32'd0);
    press(4'h7);
    enter();
    chk("disarm_keys", 32'(digit_count), 32'd0);
    chk("disarm_ack", 32'(code_ack), 32'd0);
    chk("disarm_err", 32'(entry_error), 32'd0);

    // Asynchronous reset in the middle of the ACK window.
    arm = 1'b1;
    tick();
    key_pin("rstack", 16'h2468);
    enter();
    chk("rstack_pre", 32'(code_ack), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ack", 32'(code_ack), 32'd0);
    chk("arst_code", 32'(code), 32'd0);
    chk("arst_count", 32'(digit_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("arst_after_ack", 32'(code_ack), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pin_entry_collector.md
Name: pin_entry_collector

Overview:
Keypad front-end that sits directly upstream of the parking gate controller. It assembles individually strobed keypad digits into one multi-digit PIN word. When the driver presses enter, it presents that word on code together with a held code_ack level, which the controller consumes. It also handles clear, short entries, digit overflow and inactivity timeout, so the controller only ever sees complete PINs.

Parameters:
NUM_DIGITS, 4, digits per PIN; code width = NUM_DIGITS*DIGIT_W (16 at defaults)
DIGIT_W, 4, bits per key value (hex digit)
ACK_CYCLES, 2, cycles code_ack stays high per submitted PIN (>=1)
TIMEOUT_CYCLES, 1000, idle cycles in COLLECT before a partial entry is discarded (>=2)

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-high reset
arm  input  1  level; high while a vehicle waits at the gate; low forces IDLE and discards the entry
key_valid  input  1  one-cycle strobe; key_value is a digit
key_value  input  DIGIT_W  digit value; all 2^DIGIT_W values legal
key_enter  input  1  one-cycle strobe; submit PIN
key_clear  input  1  one-cycle strobe; discard partial entry
code  output  NUM_DIGITS*DIGIT_W  assembled PIN, first digit in MS nibble
code_ack  output  1  high for ACK_CYCLES cycles when a complete PIN is presented
digit_count  output  clog2(NUM_DIGITS+1)  digits currently held
entry_error  output  1  one-cycle pulse: short enter, or digit beyond NUM_DIGITS
timeout  output  1  one-cycle pulse: partial entry discarded by inactivity

Behaviour:
- Reset (async, any state): state=IDLE; code=0; code_ack=0; digit_count=0; entry_error=0; timeout=0; timers=0. All outputs are registered.
- States: IDLE, COLLECT, ACK, RELEASE.
- IDLE: all keys ignored. When arm=1, go to COLLECT next cycle with code=0 and count=0.
- COLLECT, priority per cycle is clear > enter > digit:
  - key_clear: code=0, count=0, idle timer=0. No pulse.
  - key_enter with count==NUM_DIGITS: go to ACK. code_ack rises the next cycle. code is frozen.
  - key_enter with count<NUM_DIGITS: entry_error pulses, code=0, count=0, stay in COLLECT.
  - key_valid with count<NUM_DIGITS: code={code[W-DIGIT_W-1:0], key_value} and count+1, visible the next cycle.
  - key_valid with count==NUM_DIGITS: digit dropped, code unchanged, entry_error pulses.
- Idle timer (COLLECT only):
  - Cleared by any accepted or rejected key strobe. Otherwise increments while count>0.
  - When it reaches TIMEOUT_CYCLES-1: code=0, count=0, timer=0, timeout pulses.
  - Never fires while count==0.
- ACK:
  - code_ack=1 for exactly ACK_CYCLES cycles; code is stable for that whole window. All keys are ignored.
  - Then go to RELEASE.
- RELEASE:
  - code_ack=0 for one cycle; code=0, count=0. This guarantees the controller sees code_ack fall between attempts.
  - Then go to COLLECT (or IDLE if arm=0).
- arm=0 in any state: next state is IDLE; code, count, code_ack and timers are cleared next cycle; pending pulses are suppressed.
- Latency: enter strobe at cycle N gives code_ack=1 in cycles N+1..N+ACK_CYCLES and code_ack=0 at N+ACK_CYCLES+1. The earliest next accepted digit is at N+ACK_CYCLES+2.
- Counter widths: the ACK counter is sized for ACK_CYCLES and the idle timer for TIMEOUT_CYCLES. Neither counter wraps; both saturate and clear as specified.

Decomposition:
- Shared package/header:
  - state encodings (IDLE, COLLECT, ACK, RELEASE) alongside the existing gate-controller state defines
  - default NUM_DIGITS/DIGIT_W, so the controller's code width and this block's code width share one definition
- Sub-module: pin_idle_timer, a loadable/clearable saturating counter with a terminal-count flag. It is instantiated for the idle timeout and reused, sized down, for the ACK hold.

Test Plan:
- Async rst mid-ACK, asserted between clock edges -> code_ack=0, code=0, count=0 immediately, before the next edge.
- arm=1; keys 5,9,9,0 then enter -> code=16'h5990, code_ack high exactly 2 cycles, then low 1 cycle, then count=0.
- Keys 1,2 then enter -> entry_error pulses 1 cycle; code_ack never rises; code=0.
- Keys 1,2,3,4,7 -> fifth digit dropped with entry_error pulse. Then enter -> code=16'h1234 acked.
- Key 8, then TIMEOUT_CYCLES-1 idle cycles -> timeout pulses once, code=0. A further 2000 idle cycles -> no second pulse.
- key_valid, key_enter and key_clear in the same cycle with count=4 -> clear wins, code=0, no ack. Separately: arm drops during entry -> IDLE, subsequent keys ignored.
